// File: rtl/eq_match_monitor_if.sv
// Sample and summary handshakes between the 2-bit equality comparator path and its monitor.
// The producer and summary consumer use the master modport; the monitor uses the slave modport.
interface eq_match_monitor_if #(
  parameter int W = 2
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_x;
  logic [W-1:0] in_y;
  logic         in_eq;
  logic         out_valid;
  logic         out_ready;
  logic         out_all_eq;

  modport master (
    output in_valid, in_x, in_y, in_eq, out_ready,
    input  in_ready, out_valid, out_all_eq
  );

  modport slave (
    input  in_valid, in_x, in_y, in_eq, out_ready,
    output in_ready, out_valid, out_all_eq
  );
endinterface

// File: rtl/eq_match_monitor.sv
// Windowed monitor for comparator results: counts matches/mismatches, tracks the match streak,
// cross-checks eq against x==y and hands out one summary record per window.
module eq_match_monitor #(
  parameter int W         = 2,
  parameter int WINDOW    = 5,
  parameter int STREAK_TH = 3,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  eq_match_monitor_if.slave  bus,
  output logic               busy,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [CNT_W-1:0]   mismatch_cnt,
  output logic [CNT_W-1:0]   streak,
  output logic               streak_hit,
  output logic               chk_err
);
  localparam int SC_W = $clog2(WINDOW + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_COUNT  = 2'd1;
  localparam logic [1:0] S_REPORT = 2'd2;

  localparam logic [CNT_W-1:0] STREAK_MAX  = '1;
  localparam logic [CNT_W-1:0] STREAK_TH_C = CNT_W'(STREAK_TH);
  localparam logic [SC_W-1:0]  LAST_SAMPLE = SC_W'(WINDOW - 1);

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] match_cnt_reg, match_cnt_next;
  logic [CNT_W-1:0] mismatch_cnt_reg, mismatch_cnt_next;
  logic [CNT_W-1:0] streak_reg, streak_next;
  logic             streak_hit_reg, streak_hit_next;
  logic             chk_err_reg, chk_err_next;
  logic [SC_W-1:0]  sample_cnt_reg, sample_cnt_next;

  logic [W-1:0]     bit_same;
  logic             operands_equal;
  logic             accept;
  logic [CNT_W-1:0] streak_inc;

  // Independent reference for the comparator result, bit by bit
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit_eq
      assign bit_same[gi] = ~(bus.in_x[gi] ^ bus.in_y[gi]);
    end
  endgenerate

  assign operands_equal = &bit_same;
  assign accept         = bus.in_valid && (state_reg == S_COUNT);
  assign streak_inc     = (streak_reg == STREAK_MAX) ? STREAK_MAX : streak_reg + 1'b1;

  always_comb begin
    state_next        = state_reg;
    match_cnt_next    = match_cnt_reg;
    mismatch_cnt_next = mismatch_cnt_reg;
    streak_next       = streak_reg;
    streak_hit_next   = 1'b0;
    chk_err_next      = chk_err_reg;
    sample_cnt_next   = sample_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          match_cnt_next    = '0;
          mismatch_cnt_next = '0;
          streak_next       = '0;
          chk_err_next      = 1'b0;
          sample_cnt_next   = '0;
          state_next        = S_COUNT;
        end
      end
      S_COUNT: begin
        if (accept) begin
          if (bus.in_eq) begin
            match_cnt_next  = match_cnt_reg + 1'b1;
            streak_next     = streak_inc;
            // Fires only on the transition into the threshold, so a saturated streak cannot re-fire
            streak_hit_next = (streak_reg != STREAK_TH_C) && (streak_inc == STREAK_TH_C);
          end else begin
            mismatch_cnt_next = mismatch_cnt_reg + 1'b1;
            streak_next       = '0;
          end
          if (bus.in_eq != operands_equal) begin
            chk_err_next = 1'b1;
          end
          sample_cnt_next = sample_cnt_reg + 1'b1;
          if (sample_cnt_reg == LAST_SAMPLE) begin
            state_next = S_REPORT;
          end
        end
      end
      S_REPORT: begin
        if (bus.out_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= S_IDLE;
      match_cnt_reg    <= '0;
      mismatch_cnt_reg <= '0;
      streak_reg       <= '0;
      streak_hit_reg   <= 1'b0;
      chk_err_reg      <= 1'b0;
      sample_cnt_reg   <= '0;
    end else begin
      state_reg        <= state_next;
      match_cnt_reg    <= match_cnt_next;
      mismatch_cnt_reg <= mismatch_cnt_next;
      streak_reg       <= streak_next;
      streak_hit_reg   <= streak_hit_next;
      chk_err_reg      <= chk_err_next;
      sample_cnt_reg   <= sample_cnt_next;
    end
  end

  // Handshake outputs decode straight from state; counters are frozen while reporting
  assign bus.in_ready   = (state_reg == S_COUNT);
  assign bus.out_valid  = (state_reg == S_REPORT);
  assign bus.out_all_eq = (state_reg == S_REPORT) && (mismatch_cnt_reg == '0);

  assign busy         = (state_reg != S_IDLE);
  assign match_cnt    = match_cnt_reg;
  assign mismatch_cnt = mismatch_cnt_reg;
  assign streak       = streak_reg;
  assign streak_hit   = streak_hit_reg;
  assign chk_err      = chk_err_reg;
endmodule

// File: tb/tb_eq_match_monitor.sv
// Directed bench for eq_match_monitor: stimulus queues expected summary records,
// a separate monitor pops and compares them at each summary handshake.
module tb_eq_match_monitor;
  logic       clk;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic [7:0] match_cnt;
  logic [7:0] mismatch_cnt;
  logic [7:0] streak;
  logic       streak_hit;
  logic       chk_err;

  int checks = 0;
  int errors = 0;
  int hit_total = 0;
  logic last_hit;

  typedef struct {
    logic       all_eq;
    logic [7:0] m;
    logic [7:0] mm;
    logic [7:0] st;
    logic       ce;
  } rec_t;
  rec_t exp_q[$];

  eq_match_monitor_if #(.W(2)) bus ();

  eq_match_monitor #(
    .W(2), .WINDOW(5), .STREAK_TH(3), .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .bus(bus),
    .busy(busy),
    .match_cnt(match_cnt),
    .mismatch_cnt(mismatch_cnt),
    .streak(streak),
    .streak_hit(streak_hit),
    .chk_err(chk_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic expect_rec(input logic a, input int m, input int mm, input int st, input logic ce);
    rec_t r;
    r.all_eq = a;
    r.m      = 8'(m);
    r.mm     = 8'(mm);
    r.st     = 8'(st);
    r.ce     = ce;
    exp_q.push_back(r);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [1:0] x, input logic [1:0] y, input logic e, input int gap);
    chk("in_ready_before_send", {31'd0, bus.in_ready}, 1);
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    bus.in_y     = y;
    bus.in_eq    = e;
    @(posedge clk);
    #1;
    last_hit     = streak_hit;
    bus.in_valid = 1'b0;
    $display("sample x=%0d y=%0d eq=%0d -> match=%0d mismatch=%0d streak=%0d hit=%0d chk_err=%0d",
             x, y, e, match_cnt, mismatch_cnt, streak, streak_hit, chk_err);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic finish_window(input int hold, input logic start_at_hs);
    logic first_all_eq;
    chk("out_valid_in_report", {31'd0, bus.out_valid}, 1);
    chk("in_ready_in_report", {31'd0, bus.in_ready}, 0);
    first_all_eq = bus.out_all_eq;
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk("out_valid_hold", {31'd0, bus.out_valid}, 1);
      chk("out_all_eq_hold", {31'd0, bus.out_all_eq}, {31'd0, first_all_eq});
    end
    bus.out_ready = 1'b1;
    start         = start_at_hs;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    start         = 1'b0;
    chk("busy_after_report", {31'd0, busy}, 0);
    chk("out_valid_after_report", {31'd0, bus.out_valid}, 0);
  endtask

  // Scoreboard monitor: compares each presented summary against the oldest expectation
  initial begin : monitor
    rec_t r;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_record: got a summary record required none");
        end else begin
          r = exp_q.pop_front();
          chk("rec_out_all_eq", {31'd0, bus.out_all_eq}, {31'd0, r.all_eq});
          chk("rec_match_cnt", {24'd0, match_cnt}, {24'd0, r.m});
          chk("rec_mismatch_cnt", {24'd0, mismatch_cnt}, {24'd0, r.mm});
          chk("rec_streak", {24'd0, streak}, {24'd0, r.st});
          chk("rec_chk_err", {31'd0, chk_err}, {31'd0, r.ce});
          $display("record all_eq=%0d match=%0d mismatch=%0d streak=%0d chk_err=%0d",
                   bus.out_all_eq, match_cnt, mismatch_cnt, streak, chk_err);
        end
      end
    end
  end

  initial begin : hit_counter
    forever begin
      @(negedge clk);
      if (streak_hit === 1'b1) hit_total++;
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_match_cnt"}, {24'd0, match_cnt}, 0);
    chk({tag, "_mismatch_cnt"}, {24'd0, mismatch_cnt}, 0);
    chk({tag, "_streak"}, {24'd0, streak}, 0);
    chk({tag, "_streak_hit"}, {31'd0, streak_hit}, 0);
    chk({tag, "_chk_err"}, {31'd0, chk_err}, 0);
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 0);
    chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, 0);
    chk({tag, "_out_all_eq"}, {31'd0, bus.out_all_eq}, 0);
  endtask

  initial begin : stimulus
    int h0;
    rst_n         = 1'b0;
    start         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_x      = 2'd0;
    bus.in_y      = 2'd0;
    bus.in_eq     = 1'b0;
    bus.out_ready = 1'b0;
    last_hit      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: mixed pairs, back-to-back
    pulse_start();
    chk("t1_busy", {31'd0, busy}, 1);
    h0 = hit_total;
    expect_rec(1'b0, 2, 3, 2, 1'b0);
    send(2'd3, 2'd2, 1'b0, 0);
    send(2'd3, 2'd1, 1'b0, 0);
    send(2'd2, 2'd1, 1'b0, 0);
    send(2'd3, 2'd3, 1'b1, 0);
    send(2'd1, 2'd1, 1'b1, 0);
    finish_window(0, 1'b0);
    chk("t1_hits", hit_total - h0, 0);

    // 2: five matches, streak_hit on the cycle after the third accept
    pulse_start();
    h0 = hit_total;
    expect_rec(1'b1, 5, 0, 5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      send(2'd1, 2'd1, 1'b1, 0);
      chk("t2_hit_cycle", {31'd0, last_hit}, (i == 2) ? 1 : 0);
    end
    finish_window(0, 1'b0);
    chk("t2_hits", hit_total - h0, 1);

    // 3: inconsistent comparator result sets sticky chk_err
    pulse_start();
    expect_rec(1'b0, 4, 1, 0, 1'b1);
    send(2'd1, 2'd1, 1'b1, 0);
    chk("t3_chk_err_clean", {31'd0, chk_err}, 0);
    send(2'd3, 2'd2, 1'b1, 0);
    chk("t3_chk_err_set", {31'd0, chk_err}, 1);
    send(2'd0, 2'd0, 1'b1, 0);
    send(2'd2, 2'd2, 1'b1, 0);
    send(2'd1, 2'd0, 1'b0, 0);
    chk("t3_chk_err_report", {31'd0, chk_err}, 1);
    finish_window(0, 1'b0);
    chk("t3_chk_err_idle", {31'd0, chk_err}, 1);
    pulse_start();
    chk("t3_chk_err_cleared", {31'd0, chk_err}, 0);
    chk("t3_match_cleared", {24'd0, match_cnt}, 0);

    // 4: same pairs as test 1 with 2-cycle gaps, summary held 4 cycles
    expect_rec(1'b0, 2, 3, 2, 1'b0);
    send(2'd3, 2'd2, 1'b0, 2);
    send(2'd3, 2'd1, 1'b0, 2);
    send(2'd2, 2'd1, 1'b0, 2);
    send(2'd3, 2'd3, 1'b1, 2);
    send(2'd1, 2'd1, 1'b1, 0);
    finish_window(4, 1'b0);

    // 5: start ignored during COUNT, REPORT and at the summary handshake
    pulse_start();
    expect_rec(1'b0, 3, 2, 0, 1'b0);
    send(2'd1, 2'd1, 1'b1, 0);
    send(2'd2, 2'd2, 1'b1, 0);
    pulse_start();
    chk("t5_match_kept", {24'd0, match_cnt}, 2);
    chk("t5_busy_count", {31'd0, busy}, 1);
    send(2'd0, 2'd1, 1'b0, 0);
    send(2'd3, 2'd3, 1'b1, 0);
    send(2'd2, 2'd3, 1'b0, 0);
    pulse_start();
    chk("t5_out_valid_kept", {31'd0, bus.out_valid}, 1);
    chk("t5_match_report", {24'd0, match_cnt}, 3);
    chk("t5_mismatch_report", {24'd0, mismatch_cnt}, 2);
    finish_window(1, 1'b1);
    chk("t5_match_after_hs", {24'd0, match_cnt}, 3);
    @(posedge clk);
    #1;
    chk("t5_still_idle", {31'd0, busy}, 0);

    // 6: async reset mid-window, then a clean window
    pulse_start();
    send(2'd1, 2'd1, 1'b1, 0);
    send(2'd0, 2'd0, 1'b1, 0);
    chk("t6_match_before_rst", {24'd0, match_cnt}, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pulse_start();
    expect_rec(1'b0, 4, 1, 2, 1'b0);
    send(2'd2, 2'd2, 1'b1, 0);
    send(2'd1, 2'd1, 1'b1, 0);
    send(2'd0, 2'd1, 1'b0, 0);
    send(2'd3, 2'd3, 1'b1, 0);
    send(2'd0, 2'd0, 1'b1, 0);
    finish_window(0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
